// File: rtl/engine_pkg.sv
// ============================================================================
//  Module      : engine_pkg
//  Description : Shared widths and types for the image engine datapath.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package engine_pkg;

  localparam int DEF_IMAGE_WIDTH = 16;
  localparam int DEF_IMAGE_NB    = 3;
  localparam int WEIGHT_WIDTH    = 8;
  localparam int WORD_WIDTH      = DEF_IMAGE_WIDTH * DEF_IMAGE_NB;
  localparam int RESULT_WIDTH    = DEF_IMAGE_WIDTH + WEIGHT_WIDTH + 1;

  typedef logic [WORD_WIDTH-1:0] pixel_t;

  // Address/counter width that never collapses to zero bits.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/image_line_buffer_if.sv
// ============================================================================
//  Module      : image_line_buffer_if
//  Description : Pixel-in / column-out bundle between pixel source and engine.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface image_line_buffer_if
  import engine_pkg::*;
#(
  parameter int IMAGE_WIDTH   = DEF_IMAGE_WIDTH,
  parameter int IMAGE_NB      = DEF_IMAGE_NB,
  parameter int KERNEL_HEIGHT = 3
) ();

  localparam int c_word_w = IMAGE_WIDTH * IMAGE_NB;
  localparam int c_fill_w = clog2_min1(KERNEL_HEIGHT);

  logic [c_word_w-1:0]               pixel;
  logic                              pixel_valid;
  logic                              pixel_sof;
  logic [KERNEL_HEIGHT*c_word_w-1:0] image;
  logic                              image_valid;
  logic [c_fill_w-1:0]               row_fill;

  modport master (
    output pixel, pixel_valid, pixel_sof,
    input  image, image_valid, row_fill
  );

  modport slave (
    input  pixel, pixel_valid, pixel_sof,
    output image, image_valid, row_fill
  );

endinterface

`default_nettype wire

// File: rtl/line_ram.sv
// ============================================================================
//  Module      : line_ram
//  Description : Single-clock simple dual-port RAM, synchronous read, no reset.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module line_ram
  import engine_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int WIDTH = 96
) (
  input  wire logic                         clk,
  input  wire logic                         i_wr_en,
  input  wire logic [clog2_min1(DEPTH)-1:0] i_wr_addr,
  input  wire logic [WIDTH-1:0]             i_wr_data,
  input  wire logic                         i_rd_en,
  input  wire logic [clog2_min1(DEPTH)-1:0] i_rd_addr,
  output logic      [WIDTH-1:0]             o_rd_data
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rd_data;

  // Read returns the old word on a same-address collision; the caller forwards.
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
    if (i_rd_en) begin
      r_rd_data <= r_mem[i_rd_addr];
    end
  end

  assign o_rd_data = r_rd_data;

endmodule

`default_nettype wire

// File: rtl/image_line_buffer.sv
// ============================================================================
//  Module      : image_line_buffer
//  Description : Turns a raster pixel stream into KERNEL_HEIGHT-tall columns.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module image_line_buffer
  import engine_pkg::*;
#(
  parameter int IMAGE_WIDTH   = DEF_IMAGE_WIDTH,
  parameter int IMAGE_NB      = DEF_IMAGE_NB,
  parameter int KERNEL_HEIGHT = 3,
  parameter int LINE_WIDTH    = 64
) (
  input wire logic     clk,
  input wire logic     rst,
  image_line_buffer_if.slave bus
);

  localparam int c_word_w = IMAGE_WIDTH * IMAGE_NB;
  localparam int c_mem_w  = (KERNEL_HEIGHT - 1) * c_word_w;
  localparam int c_col_w  = clog2_min1(LINE_WIDTH);
  localparam int c_fill_w = clog2_min1(KERNEL_HEIGHT);
  localparam logic [c_col_w-1:0]  c_last_col = c_col_w'(LINE_WIDTH - 1);
  localparam logic [c_fill_w-1:0] c_full     = c_fill_w'(KERNEL_HEIGHT - 1);

  logic [c_col_w-1:0]                r_col, w_col_eff, r_s1_col;
  logic [c_fill_w-1:0]               r_row_fill, w_fill_eff;
  logic                              r_s1_valid, r_s1_emit, r_s1_fwd;
  logic [c_word_w-1:0]               r_s1_pixel;
  logic [c_mem_w-1:0]                w_rd_data, w_s1_lines, w_wr_data, r_fwd_data;
  logic                              w_wr_en;
  logic [KERNEL_HEIGHT*c_word_w-1:0] r_image;
  logic                              r_image_valid;

  always_comb begin
    w_col_eff  = bus.pixel_sof ? '0 : r_col;
    w_fill_eff = bus.pixel_sof ? '0 : r_row_fill;
    w_s1_lines = r_s1_fwd ? r_fwd_data : w_rd_data;
  end

  // Oldest line drops out; the incoming pixel becomes the newest stored line.
  if (KERNEL_HEIGHT == 2) begin : g_wr_single
    assign w_wr_data = r_s1_pixel;
  end else begin : g_wr_shift
    assign w_wr_data = {r_s1_pixel, w_s1_lines[c_mem_w-1:c_word_w]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_col      <= '0;
      r_row_fill <= '0;
    end else if (bus.pixel_valid) begin
      r_col <= (w_col_eff == c_last_col) ? '0 : w_col_eff + 1'b1;
      if (w_col_eff == c_last_col && w_fill_eff != c_full) begin
        r_row_fill <= w_fill_eff + 1'b1;
      end else begin
        r_row_fill <= w_fill_eff;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_emit  <= 1'b0;
      r_s1_fwd   <= 1'b0;
    end else begin
      r_s1_valid <= bus.pixel_valid;
      r_s1_emit  <= bus.pixel_valid && (w_fill_eff == c_full);
      r_s1_fwd   <= bus.pixel_valid && r_s1_valid && (r_s1_col == w_col_eff);
    end
    r_s1_pixel <= bus.pixel;
    r_s1_col   <= w_col_eff;
    r_fwd_data <= w_wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_image_valid <= 1'b0;
      r_image       <= '0;
    end else begin
      r_image_valid <= r_s1_emit;
      r_image       <= r_s1_emit ? {r_s1_pixel, w_s1_lines} : '0;
    end
  end

  assign w_wr_en = r_s1_valid && !rst;

  line_ram #(
    .DEPTH (LINE_WIDTH),
    .WIDTH (c_mem_w)
  ) u_line_ram (
    .clk       (clk),
    .i_wr_en   (w_wr_en),
    .i_wr_addr (r_s1_col),
    .i_wr_data (w_wr_data),
    .i_rd_en   (bus.pixel_valid),
    .i_rd_addr (w_col_eff),
    .o_rd_data (w_rd_data)
  );

  assign bus.image       = r_image;
  assign bus.image_valid = r_image_valid;
  assign bus.row_fill    = r_row_fill;

endmodule

`default_nettype wire

// File: tb/tb_image_line_buffer.sv
// ============================================================================
//  Module      : tb_image_line_buffer
//  Description : Directed bench for image_line_buffer (K=3, 4-pixel lines).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_image_line_buffer;

  localparam int c_k  = 3;
  localparam int c_lw = 4;
  localparam int c_iw = 16;
  localparam int c_nb = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  image_line_buffer_if #(
    .IMAGE_WIDTH   (c_iw),
    .IMAGE_NB      (c_nb),
    .KERNEL_HEIGHT (c_k)
  ) bus ();

  image_line_buffer #(
    .IMAGE_WIDTH   (c_iw),
    .IMAGE_NB      (c_nb),
    .KERNEL_HEIGHT (c_k),
    .LINE_WIDTH    (c_lw)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk = 0;
  int n_err = 0;
  int v00   = 0;

  // Expectations for the two pixels still inside the pipeline.
  bit             arm0 = 1'b0, arm1 = 1'b0;
  logic [143:0]   exp0 = '0,   exp1 = '0;

  task automatic check(input string tag, input logic [143:0] got, input logic [143:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic engine_pkg::pixel_t px(input int v);
    logic [15:0] s;
    s = v[15:0];
    return {s, s, s};
  endfunction

  function automatic logic [143:0] col3(input int a, input int b, input int c);
    return {px(c), px(b), px(a)};
  endfunction

  function automatic int pv(input int r, input int c);
    return (r == 0 && c == 0) ? v00 : 10 * r + c;
  endfunction

  // One clock: check the output owed by the pixel of two cycles ago, then drive.
  task automatic cyc(input bit r, input bit vld, input bit sof, input int v,
                     input logic [143:0] e);
    @(negedge clk);
    if (arm1) begin
      check("image_valid", {143'b0, bus.image_valid}, {143'b0, (exp1 != '0)});
      check("image", bus.image, exp1);
    end
    arm1 = arm0;
    exp1 = exp0;
    arm0 = 1'b1;
    exp0 = e;
    rst             = r;
    bus.pixel_valid = vld;
    bus.pixel_sof   = sof;
    bus.pixel       = px(v);
  endtask

  task automatic chk_fill(input int e);
    @(posedge clk);
    #1;
    check("row_fill", {142'b0, bus.row_fill}, 144'(e));
  endtask

  task automatic send_frame(input int first, input int last, input bit kill_last);
    for (int idx = first; idx <= last; idx++) begin
      int r, c;
      logic [143:0] e;
      r = idx / c_lw;
      c = idx % c_lw;
      e = (r >= 2) ? col3(pv(r - 2, c), pv(r - 1, c), pv(r, c)) : '0;
      if (kill_last && idx == last) e = '0;
      cyc(1'b0, 1'b1, idx == 0, pv(r, c), e);
      if (c == c_lw - 1) chk_fill((r == 0) ? 1 : 2);
    end
  endtask

  initial begin
    bus.pixel       = '0;
    bus.pixel_valid = 1'b0;
    bus.pixel_sof   = 1'b0;

    // Reset held with traffic toggling, then released.
    for (int i = 0; i < 6; i++) begin
      cyc(1'b1, i[0], 1'b0, 99, '0);
      chk_fill(0);
    end
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, 0, '0);
    chk_fill(0);

    // Frame start plus steady-state row 3.
    send_frame(0, 15, 1'b0);

    // Row 4 with long idle gaps.
    for (int c = 0; c < c_lw; c++) begin
      cyc(1'b0, 1'b1, 1'b0, 40 + c, col3(20 + c, 30 + c, 40 + c));
      for (int g = 0; g < 20; g++) cyc(1'b0, 1'b0, 1'b0, 0, '0);
    end

    // Row 5 cut short by a new frame at column 2.
    cyc(1'b0, 1'b1, 1'b0, 50, col3(30, 40, 50));
    cyc(1'b0, 1'b1, 1'b0, 51, col3(31, 41, 51));
    cyc(1'b0, 1'b1, 1'b1, 0, '0);
    chk_fill(0);
    send_frame(1, 8, 1'b0);

    // Back-to-back sof, then reset while a column is in flight.
    cyc(1'b0, 1'b1, 1'b1, 7, '0);
    cyc(1'b0, 1'b1, 1'b1, 8, '0);
    v00 = 8;
    send_frame(1, 9, 1'b1);
    cyc(1'b1, 1'b1, 1'b0, 22, '0);
    cyc(1'b1, 1'b0, 1'b0, 0, '0);
    cyc(1'b0, 1'b0, 1'b0, 0, '0);
    cyc(1'b0, 1'b0, 1'b0, 0, '0);
    chk_fill(0);

    // Fresh frame after reset.
    v00 = 0;
    send_frame(0, 11, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, 0, '0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
